mux_pipe: RTL

Parametrised, registered N-to-1 selector with a valid/ready handshake and a two-entry skid buffer. It replaces the combinational 4-way operand/result selectors at pipeline stage boundaries, such as EX→MEM result select and writeback source select, where selection must be registered and the downstream stage can stall. Flush support lets the hazard unit squash the stage on branch or exception.

---
 rtl/mux_pipe.sv | 87 ++++++++
 1 files changed

// File: rtl/mux_pipe.sv
// rtl/mux_pipe.sv - registered N-to-1 selector with valid/ready handshake and skid buffer
module mux_pipe #(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;

  logic [WIDTH-1:0] main_data, skid_data;
  logic [SEL_W-1:0] main_sel, skid_sel;
  logic             main_err, skid_err;
  logic             main_valid, skid_valid;
  logic             accept;

  // Out-of-range indices fall back to channel 0 and are flagged.
  always_comb begin
    sel_data = in_data[WIDTH-1:0];
    sel_err  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_data  <= '0;
      main_sel   <= '0;
      main_err   <= 1'b0;
      main_valid <= 1'b0;
      skid_data  <= '0;
      skid_sel   <= '0;
      skid_err   <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      // Only the valid flags clear; payload registers keep stale contents.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_ready) begin
      if (skid_valid) begin
        main_data  <= skid_data;
        main_sel   <= skid_sel;
        main_err   <= skid_err;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_data  <= sel_data;
        main_sel   <= in_sel;
        main_err   <= sel_err;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_data  <= sel_data;
      skid_sel   <= in_sel;
      skid_err   <= sel_err;
      skid_valid <= 1'b1;
    end
  end

  assign out_data  = main_data;
  assign out_sel   = main_sel;
  assign out_err   = main_err;
  assign out_valid = main_valid;

endmodule
